// File: rtl/beep_note_pkg.sv
// Shared types and constants for the buzzer note decoder: note table, note codes,
// FSM state encoding and the period classifier.
package beep_note_pkg;

  typedef enum logic [3:0] {
    DO  = 4'd0,
    RE  = 4'd1,
    MI  = 4'd2,
    FA  = 4'd3,
    SO  = 4'd4,
    LA  = 4'd5,
    XI  = 4'd6,
    DOO = 4'd7
  } note_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ACQ  = 2'd1;
  localparam state_t ST_TONE = 2'd2;

  localparam logic [17:0] NOTE_PERIOD [8] = '{
    18'd190841, 18'd170069, 18'd151516, 18'd143267,
    18'd127552, 18'd113637, 18'd101215, 18'd95557
  };

  typedef struct packed {
    logic  hit;
    note_t code;
  } note_class_t;

  // Table periods are far more than 2*tol apart, so the first hit is the only hit.
  function automatic note_class_t classify(input logic [17:0] p, input logic [17:0] tol);
    note_class_t r;
    logic [17:0] d;
    r.hit  = 1'b0;
    r.code = DO;
    for (int unsigned k = 0; k < 8; k++) begin
      d = (p >= NOTE_PERIOD[k]) ? p - NOTE_PERIOD[k] : NOTE_PERIOD[k] - p;
      if (!r.hit && d <= tol) begin
        r.hit  = 1'b1;
        r.code = note_t'(k[3:0]);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/beep_note_decoder_if.sv
// Decoded-note output bundle of beep_note_decoder; master drives, slave observes.
interface beep_note_decoder_if;
  logic [3:0]  note_code;
  logic [3:0]  note_beats;
  logic        note_valid;
  logic        tone_active;
  logic [17:0] period_meas;

  modport master (output note_code, note_beats, note_valid, tone_active, period_meas);
  modport slave  (input  note_code, note_beats, note_valid, tone_active, period_meas);
endinterface

// File: rtl/beep_period_meter.sv
// Synchronizes tone_in, detects rising edges and measures edge-to-edge period.
// Optional glitch filter enabled by defining BEEP_DEC_GLITCH_FILTER_EN.
module beep_period_meter
  import beep_note_pkg::*;
#(
  parameter logic [17:0] SILENCE_CYC = 18'd262143
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tone_in,
  output logic        rise,
  output logic [17:0] period,
  output logic        silent
);
  logic        s1, s2;
  logic        level, level_d;
  logic [17:0] cnt;

`ifdef BEEP_DEC_GLITCH_FILTER_EN
  // Flip only once 4 consecutive samples disagree with the current filtered level.
  logic       filt;
  logic [1:0] run;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= 1'b0;
      run  <= '0;
    end else if (s2 == filt) begin
      run <= '0;
    end else if (run == 2'd3) begin
      filt <= s2;
      run  <= '0;
    end else begin
      run <= run + 2'd1;
    end
  end
  assign level = filt;
`else
  assign level = s2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      level_d <= 1'b0;
      rise    <= 1'b0;
      period  <= '0;
      cnt     <= '0;
    end else begin
      s1      <= tone_in;
      s2      <= s1;
      level_d <= level;
      rise    <= level & ~level_d;
      // period is registered alongside rise so the consumer sees a fresh value with the pulse
      if (level & ~level_d) begin
        period <= (cnt == '1) ? cnt : cnt + 18'd1;
        cnt    <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + 18'd1;
      end
    end
  end

  assign silent = (cnt >= SILENCE_CYC);

endmodule

// File: rtl/beep_note_decoder.sv
// Buzzer note decoder: locks onto a stable tone period and reports the note and its
// duration in rounded half-beat units.
module beep_note_decoder
  import beep_note_pkg::*;
#(
  parameter logic [17:0] NOTE_TOL      = 18'd1024,
  parameter logic [17:0] SILENCE_CYC   = 18'd262143,
  parameter logic [25:0] HALF_BEAT_CYC = 26'd24_999_999
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tone_in,
  beep_note_decoder_if.master note_if
);
  logic [1:0]  rst_sync;
  logic        rst_ni;
  logic        rise, silent;
  logic [17:0] period;
  note_class_t cls, cand;
  note_t       lock_code;
  state_t      state;
  logic [25:0] dur_sub, snap_sub;
  logic [3:0]  dur_q, snap_q;
  logic [3:0]  note_code_r, note_beats_r;
  logic        note_valid_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_ni = rst_sync[1];

  beep_period_meter #(.SILENCE_CYC(SILENCE_CYC)) u_meter (
    .clk    (clk),
    .rst_n  (rst_ni),
    .tone_in(tone_in),
    .rise   (rise),
    .period (period),
    .silent (silent)
  );

  assign cls = classify(period, NOTE_TOL);

  function automatic logic [3:0] round_beats(input logic [3:0] q, input logic [25:0] sub);
    if (q == 4'd15) return 4'd15;
    return q + {3'b000, (sub >= (HALF_BEAT_CYC >> 1))};
  endfunction

  // Duration is kept as (beats, sub-beat cycles); it is seeded with 1 on the entry
  // rise so it holds the full rise-to-rise cycle count when the next rise arrives.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= ST_IDLE;
      cand         <= '0;
      lock_code    <= DO;
      dur_sub      <= '0;
      dur_q        <= '0;
      snap_sub     <= '0;
      snap_q       <= '0;
      note_code_r  <= '0;
      note_beats_r <= '0;
      note_valid_r <= 1'b0;
    end else begin
      note_valid_r <= 1'b0;
      if (dur_q != 4'd15) begin
        if (dur_sub == HALF_BEAT_CYC - 26'd1) begin
          dur_sub <= '0;
          dur_q   <= dur_q + 4'd1;
        end else begin
          dur_sub <= dur_sub + 26'd1;
        end
      end
      case (state)
        ST_IDLE: if (rise) begin
          state   <= ST_ACQ;
          cand    <= '0;
          dur_sub <= 26'd1;
          dur_q   <= '0;
        end
        ST_ACQ: if (rise) begin
          if (cls.hit && cand.hit && cls.code == cand.code) begin
            state     <= ST_TONE;
            lock_code <= cls.code;
            snap_sub  <= dur_sub;
            snap_q    <= dur_q;
          end else begin
            cand <= cls;
          end
        end else if (silent) begin
          state <= ST_IDLE;
        end
        ST_TONE: if (rise) begin
          if (cls.hit && cls.code == lock_code) begin
            snap_sub <= dur_sub;
            snap_q   <= dur_q;
          end else begin
            note_valid_r <= 1'b1;
            note_code_r  <= lock_code;
            note_beats_r <= round_beats(dur_q, dur_sub);
            state        <= ST_ACQ;
            cand         <= cls;
            dur_sub      <= 26'd1;
            dur_q        <= '0;
          end
        end else if (silent) begin
          note_valid_r <= 1'b1;
          note_code_r  <= lock_code;
          note_beats_r <= round_beats(snap_q, snap_sub);
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign note_if.note_code   = note_code_r;
  assign note_if.note_beats  = note_beats_r;
  assign note_if.note_valid  = note_valid_r;
  assign note_if.tone_active = (state == ST_TONE);
  assign note_if.period_meas = period;

endmodule
